sensor_snapshot_bank: RTL and testbench

Parametrised sensor register bank that captures NUM_CH multi-byte sensor channels on per-channel valid strobes. It serves them to the flight processor's byte-wide read bus.
Adds what the previous fixed-map bank lacked: a registered read handshake, tear-free multi-byte reads via a coherency shadow, per-channel fresh/stale tracking, a global freeze, and a defined out-of-range response.
Sits between the sensor interface blocks (altimeter, IMU, magnetometer, GPS) and the bus-slave decoder.

---
 rtl/sensor_pkg.sv | 17 +
 rtl/sensor_age_ctr.sv | 31 +++
 rtl/sensor_snapshot_bank.sv | 123 ++++++++++++
 tb/tb_sensor_snapshot_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared constants and address-map helpers for the sensor snapshot bank.
package sensor_pkg;

   localparam int         SENSOR_ADDR_W = 8;
   localparam logic [7:0] ID_BYTE_DFLT  = 8'hA5;

   // Address 0 is the ID byte; channel bytes start at address 1.
   function automatic int ch_of(input int addr, input int ch_bytes);
      return (addr - 1) / ch_bytes;
   endfunction

   // Byte index within a channel, 0 = MSB.
   function automatic int byte_of(input int addr, input int ch_bytes);
      return (addr - 1) % ch_bytes;
   endfunction

endpackage

// File: rtl/sensor_age_ctr.sv
// Per-channel saturating age counter; stale while the count sits at STALE_MAX.
module sensor_age_ctr
   import sensor_pkg::*;
#(
   parameter int STALE_MAX = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic stale
);

   localparam int             AW      = $clog2(STALE_MAX + 1);
   localparam logic [AW-1:0]  AGE_MAX = AW'(STALE_MAX);

   logic [AW-1:0] age;

   // Restart on capture, otherwise count up and hold at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age <= '0;
      end else if (clear) begin
         age <= '0;
      end else if (age != AGE_MAX) begin
         age <= age + 1'b1;
      end
   end

   assign stale = (age == AGE_MAX);

endmodule

// File: rtl/sensor_snapshot_bank.sv
// Sensor register bank: per-channel capture, byte-wide registered reads with
// a single coherency shadow for untorn multi-byte reads, fresh/stale flags.
module sensor_snapshot_bank
   import sensor_pkg::*;
#(
   parameter int         NUM_CH    = 12,
   parameter int         CH_BYTES  = 2,
   parameter int         ADDR_W    = SENSOR_ADDR_W,
   parameter int         STALE_MAX = 1000,
   parameter logic [7:0] ID_BYTE   = ID_BYTE_DFLT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
   input  logic [NUM_CH-1:0]            ch_valid,
   input  logic                         freeze,
   input  logic                         rd_req,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic [7:0]                   rd_data,
   output logic                         rd_ack,
   output logic [NUM_CH-1:0]            fresh,
   output logic [NUM_CH-1:0]            stale
);

   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int DW        = CH_BYTES * 8;
   localparam int LAST_ADDR = NUM_CH * CH_BYTES;

   logic [DW-1:0]     ch_reg [NUM_CH];
   logic [DW-1:0]     shadow;
   logic [CH_W-1:0]   sh_tag;
   logic              sh_vld;
   logic [NUM_CH-1:0] cap;

   int                a_int;
   int                byte_int;
   logic              in_range;
   logic              is_msb;
   logic [CH_W-1:0]   sel_ch;
   logic [DW-1:0]     src;
   logic [7:0]        rd_mux;

   assign cap = ch_valid & {NUM_CH{~freeze}};

   // Address decode and read mux; non-MSB bytes come from the shadow when it
   // was last loaded by this same channel.
   always_comb begin
      a_int    = int'(rd_addr);
      in_range = (a_int >= 1) && (a_int <= LAST_ADDR);
      sel_ch   = '0;
      byte_int = 0;
      if (in_range) begin
         sel_ch   = CH_W'(ch_of(a_int, CH_BYTES));
         byte_int = byte_of(a_int, CH_BYTES);
      end
      is_msb = in_range && (byte_int == 0);
      src    = ch_reg[sel_ch];
      if (!is_msb && sh_vld && (sh_tag == sel_ch)) begin
         src = shadow;
      end
      rd_mux = 8'h00;
      if (a_int == 0) begin
         rd_mux = ID_BYTE;
      end else if (in_range) begin
         rd_mux = src[(CH_BYTES - 1 - byte_int) * 8 +: 8];
      end
   end

   // Channel capture registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) ch_reg[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (cap[k]) ch_reg[k] <= ch_data[k*DW +: DW];
         end
      end
   end

   // Fresh flags: capture sets (and wins over a same-edge MSB read), MSB read clears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fresh <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (cap[k]) begin
               fresh[k] <= 1'b1;
            end else if (rd_req && is_msb && (sel_ch == CH_W'(k))) begin
               fresh[k] <= 1'b0;
            end
         end
      end
   end

   // Registered read response and shadow load on MSB reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ack  <= 1'b0;
         rd_data <= 8'h00;
         shadow  <= '0;
         sh_tag  <= '0;
         sh_vld  <= 1'b0;
      end else begin
         rd_ack <= rd_req;
         if (rd_req) rd_data <= rd_mux;
         if (rd_req && is_msb) begin
            shadow <= ch_reg[sel_ch];
            sh_tag <= sel_ch;
            sh_vld <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_age
      sensor_age_ctr #(.STALE_MAX(STALE_MAX)) u_age (
         .clk   (clk),
         .rst   (rst),
         .clear (cap[k]),
         .stale (stale[k])
      );
   end

endmodule

// File: tb/tb_sensor_snapshot_bank.sv
// Directed bench for sensor_snapshot_bank (12 channels x 2 bytes, STALE_MAX=8).
module tb_sensor_snapshot_bank;

   localparam int NUM_CH   = 12;
   localparam int CH_BYTES = 2;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [NUM_CH*CH_BYTES*8-1:0] ch_data;
   logic [NUM_CH-1:0]            ch_valid;
   logic                         freeze;
   logic                         rd_req;
   logic [7:0]                   rd_addr;
   logic [7:0]                   rd_data;
   logic                         rd_ack;
   logic [NUM_CH-1:0]            fresh;
   logic [NUM_CH-1:0]            stale;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] exp;
   } rd_vec_t;

   rd_vec_t tbl[14];

   sensor_snapshot_bank #(
      .NUM_CH    (NUM_CH),
      .CH_BYTES  (CH_BYTES),
      .ADDR_W    (8),
      .STALE_MAX (8),
      .ID_BYTE   (8'hA5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_data  (ch_data),
      .ch_valid (ch_valid),
      .freeze   (freeze),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_ack   (rd_ack),
      .fresh    (fresh),
      .stale    (stale)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
      rd_req  = 1'b1;
      rd_addr = a;
      step();
      rd_req  = 1'b0;
      check({nm, "_ack"}, 32'(rd_ack), 32'd1);
      check(nm, 32'(rd_data), 32'(exp));
   endtask

   task automatic capture(input int k, input logic [15:0] v);
      ch_valid[k]        = 1'b1;
      ch_data[k*16 +: 16] = v;
      step();
      ch_valid = '0;
   endtask

   initial begin
      tbl[0]  = '{8'd0,   8'hA5};
      tbl[1]  = '{8'd1,   8'h10};
      tbl[2]  = '{8'd2,   8'hC0};
      tbl[3]  = '{8'd11,  8'h15};
      tbl[4]  = '{8'd12,  8'hC5};
      tbl[5]  = '{8'd23,  8'h1B};
      tbl[6]  = '{8'd24,  8'hCB};
      tbl[7]  = '{8'd13,  8'h16};
      tbl[8]  = '{8'd14,  8'hC6};
      tbl[9]  = '{8'd25,  8'h00};
      tbl[10] = '{8'd26,  8'h00};
      tbl[11] = '{8'd255, 8'h00};
      tbl[12] = '{8'd0,   8'hA5};
      tbl[13] = '{8'd200, 8'h00};

      rst = 1'b1; ch_data = '0; ch_valid = '0; freeze = 1'b0;
      rd_req = 1'b0; rd_addr = '0;
      repeat (2) step();
      check("rst_ack", 32'(rd_ack), 32'd0);
      check("rst_data", 32'(rd_data), 32'd0);

      // Reset and ID: release, then reset again with a request pending
      rst = 1'b0;
      rd_req = 1'b1; rd_addr = 8'd0;
      @(negedge clk);
      rst = 1'b1;
      rd_req = 1'b0;
      step();
      check("midrd_ack_in_rst", 32'(rd_ack), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("midrd_ack_after", 32'(rd_ack), 32'd0);
      check("rst_fresh", 32'(fresh), 32'd0);
      check("rst_stale", 32'(stale), 32'd0);
      rd(8'd0, 8'hA5, "id");
      step();
      check("idle_ack", 32'(rd_ack), 32'd0);
      check("idle_hold", 32'(rd_data), 32'hA5);

      // Capture and read
      capture(3, 16'hBEEF);
      check("fresh3_set", 32'(fresh[3]), 32'd1);
      rd(8'd7, 8'hBE, "ch3_msb");
      check("fresh3_clr", 32'(fresh[3]), 32'd0);
      rd(8'd8, 8'hEF, "ch3_lsb");

      // Tear protection
      capture(0, 16'h1234);
      rd(8'd1, 8'h12, "tear_msb");
      capture(0, 16'hABCD);
      rd(8'd2, 8'h34, "tear_shadow");
      rd(8'd1, 8'hAB, "tear_msb2");
      rd(8'd2, 8'hCD, "tear_lsb2");

      // Freeze and stale
      capture(1, 16'h1111);
      freeze = 1'b1;
      ch_valid[1] = 1'b1;
      ch_data[16 +: 16] = 16'h5555;
      step();
      ch_valid = '0;
      check("frz_fresh1", 32'(fresh[1]), 32'd1);
      repeat (6) step();
      check("stale1_age7", 32'(stale[1]), 32'd0);
      step();
      check("stale1_age8", 32'(stale[1]), 32'd1);
      step();
      check("stale1_sat", 32'(stale[1]), 32'd1);
      rd(8'd3, 8'h11, "frz_msb");
      rd(8'd4, 8'h11, "frz_lsb");
      check("frz_fresh1_rd", 32'(fresh[1]), 32'd0);
      freeze = 1'b0;
      capture(1, 16'h2222);
      check("stale1_clr", 32'(stale[1]), 32'd0);
      check("fresh1_new", 32'(fresh[1]), 32'd1);
      rd(8'd3, 8'h22, "unfrz_msb");

      // Same-edge capture and MSB read
      capture(2, 16'h0102);
      ch_valid[2] = 1'b1;
      ch_data[32 +: 16] = 16'h0A0B;
      rd_req = 1'b1; rd_addr = 8'd5;
      step();
      ch_valid = '0; rd_req = 1'b0;
      check("coll_ack", 32'(rd_ack), 32'd1);
      check("coll_msb", 32'(rd_data), 32'h01);
      check("coll_fresh2", 32'(fresh[2]), 32'd1);
      rd(8'd6, 8'h02, "coll_lsb");
      rd(8'd5, 8'h0A, "coll_msb2");
      check("coll_fresh2_clr", 32'(fresh[2]), 32'd0);
      rd(8'd6, 8'h0B, "coll_lsb2");

      // Back-to-back with out-of-range addresses
      capture(11, 16'h7788);
      rd_req = 1'b1; rd_addr = 8'd24;
      step();
      check("b2b0_ack", 32'(rd_ack), 32'd1);
      check("b2b0_data", 32'(rd_data), 32'h88);
      rd_addr = 8'd25;
      step();
      check("b2b1_ack", 32'(rd_ack), 32'd1);
      check("b2b1_data", 32'(rd_data), 32'h00);
      rd_addr = 8'd200;
      step();
      check("b2b2_ack", 32'(rd_ack), 32'd1);
      check("b2b2_data", 32'(rd_data), 32'h00);
      rd_req = 1'b0;
      step();
      check("b2b_end_ack", 32'(rd_ack), 32'd0);

      // Capture every channel at once, then walk the read table
      for (int k = 0; k < NUM_CH; k++) begin
         ch_data[k*16 +: 16] = {8'(8'h10 + k), 8'(8'hC0 + k)};
      end
      ch_valid = '1;
      step();
      ch_valid = '0;
      check("all_fresh", 32'(fresh), 32'hFFF);
      check("all_stale", 32'(stale), 32'd0);
      for (int i = 0; i < 14; i++) begin
         rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_a%0d", i, tbl[i].addr));
      end
      check("tbl_fresh", 32'(fresh), 32'h79E);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
